mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester front end for the single-ported unified instruction/data memory of the pipelined core. It arbitrates between the fetch stage (IF) and the memory stage (D) and drives one shared memory port. It tracks which requester owns the outstanding read and steers the returning read data back to that requester, holding the last value per requester. This is the response-side counterpart of the pipeline's operand/address selection muxes: one stream in, routed to one of two destinations with state.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive IF denials before IF is forced to win (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data (held between responses)
- d_req  in  1  data request
- d_we  in  1  data write enable (1 = store)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data (held between responses)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_en=1, mem_we=0

## Operation
- Grant (combinational): force_if = (starve_cnt == STARVE_LIMIT).
  - force_if=1 and if_req=1: IF wins.
  - Otherwise D wins whenever d_req=1.
  - IF wins when if_req=1 and d_req=0.
- At most one of if_gnt/d_gnt is high in any cycle.
- Memory port follows the winner combinationally:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr/mem_wdata come from the winner; mem_wdata = 0 when IF wins.
- Response FSM (registered), states IDLE, RESP_IF, RESP_D. Next state from this cycle's grant:
  - IF granted → RESP_IF.
  - D granted with d_we=0 → RESP_D.
  - Store or no grant → IDLE.
  - Transitions are taken from any state; back-to-back reads are fully pipelined.
- In RESP_IF: if_rvalid=1, if_rdata = mem_rdata (bypass), and if_hold ← mem_rdata. RESP_D is symmetric for the d_* outputs.
- Outside its response cycle, each xx_rdata = xx_hold and xx_rvalid = 0.
- Stores produce no response; d_rvalid stays 0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when if_req=1 and if_gnt=0.
  - Clears when if_gnt=1 or if_req=0.

## Timing
- Read latency: grant in cycle N → rvalid/rdata in cycle N+1. Store completes in the grant cycle.
- Requester holds req/addr/data stable until its gnt; a request may be withdrawn before grant.
- Simultaneous if_req and d_req:
  - D wins unless force_if.
  - IF wins the cycle after STARVE_LIMIT consecutive denials; counter then clears.
- Response cycle with a new grant: both happen in the same cycle (old data steered out, new owner registered).
- Reset (asynchronous, active-low, any time): state IDLE, if_hold=d_hold=0, starve_cnt=0.
  - Outputs during/after reset: rvalids 0, rdatas 0. Gnts and mem_* are combinational from inputs (mem_en=0 when no request).
  - A read in flight at reset is discarded; mem_rdata is ignored in the first cycle after release.

## Structure
- Shared package (core package): arb_state_t enum {IDLE, RESP_IF, RESP_D}; default widths ADDR_W/DATA_W already defined there.
- One sub-module: resp_hold_demux.
  - Takes mem_rdata, a 2-bit one-hot target, clk, and rst.
  - Produces both rvalid/rdata pairs with their hold registers.
  - Instantiated once.
- Grant logic, starvation counter, and FSM live in the top.

## Test plan
- Reset then idle: all rvalid 0, if_rdata=d_rdata=0, mem_en=0.
- IF read alone: if_req=1, if_addr=0x40 (mem holds 0x00A00093) → if_gnt=1 same cycle; next cycle if_rvalid=1, if_rdata=0x00A00093; stays 0x00A00093 afterwards with if_rvalid=0.
- Contention: if_req=d_req=1, d_we=0, continuous, STARVE_LIMIT=4 → D granted 4 cycles, IF granted cycle 5, D resumes cycle 6; each response lands on the correct port.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_we=1 that cycle; d_rvalid stays 0; later load of 0x100 returns 0xDEADBEEF.
- Pipelined reads: IF read then D read in consecutive cycles → if_rvalid in cycle 2, d_rvalid in cycle 3, no overlap or swap.
- Reset mid-read: assert rst the cycle after an IF grant → if_rvalid stays 0, if_rdata=0, state IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  // Which requester owns the read data arriving this cycle.
  typedef enum logic [1:0] {
    IDLE,
    RESP_IF,
    RESP_D
  } arb_state_t;

endpackage

// File: rtl/resp_hold_demux.sv
// Steers returning read data to the owning requester and keeps the
// last value each requester received.
module resp_hold_demux #(
  parameter int unsigned DATA_W = mem_port_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        target,     // bit0 = IF, bit1 = D (one-hot or zero)
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  logic [DATA_W-1:0] if_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  // Capture the response into the owner's hold register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_hold_q <= '0;
      d_hold_q  <= '0;
    end else begin
      if (target[0]) if_hold_q <= mem_rdata;
      if (target[1]) d_hold_q  <= mem_rdata;
    end
  end

  // Bypass the live data during the response cycle, otherwise show the hold.
  always_comb begin
    if_rvalid = target[0];
    d_rvalid  = target[1];
    if_rdata  = target[0] ? mem_rdata : if_hold_q;
    d_rdata   = target[1] ? mem_rdata : d_hold_q;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-ported
// unified memory with one-cycle read latency.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = mem_port_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W       = mem_port_arbiter_pkg::DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mem_port_arbiter_pkg::*;

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;
  arb_state_t      state_q, state_d;
  logic            force_if;
  logic [1:0]      target;

  // Grant: D has priority unless IF has been denied STARVE_LIMIT times in a row.
  always_comb begin
    force_if = (starve_q == StarveMax);
    if_gnt   = if_req & (force_if | ~d_req);
    d_gnt    = d_req & ~(force_if & if_req);
  end

  // Memory port follows the winner.
  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = if_gnt ? if_addr : d_addr;
    mem_wdata = if_gnt ? '0 : d_wdata;
  end

  // Starvation counter next state: count denials, clear on grant or idle.
  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end
  end

  // Response owner for next cycle, taken from this cycle's grant.
  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (d_gnt && !d_we) begin
      state_d = RESP_D;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Decode the owner into a one-hot steering target.
  always_comb begin
    target = {state_q == RESP_D, state_q == RESP_IF};
  end

  resp_hold_demux #(
    .DATA_W (DATA_W)
  ) u_resp_hold_demux (
    .clk       (clk),
    .rst       (rst),
    .mem_rdata (mem_rdata),
    .target    (target),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small one-cycle-latency memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: word-addressed, read data one cycle after the strobe,
  // and a poison pattern on cycles without a read.
  logic [31:0] mem [256];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[16]   <= 32'h00A0_0093;  // 0x40
      mem[32]   <= 32'h1234_5678;  // 0x80
      mem_rdata <= 32'hBADB_AD00;
    end else begin
      mem_rdata <= 32'hBADB_AD00;
      if (mem_en) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        else        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle.
    #12;
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_d_rvalid",  {31'b0, d_rvalid},  32'd0);
    chk("rst_if_rdata",  if_rdata, 32'h0);
    chk("rst_d_rdata",   d_rdata,  32'h0);
    chk("rst_mem_en",    {31'b0, mem_en}, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("idle_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("idle_mem_en",    {31'b0, mem_en},    32'd0);

    // IF read alone.
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("ifrd_if_gnt",    {31'b0, if_gnt}, 32'd1);
    chk("ifrd_d_gnt",     {31'b0, d_gnt},  32'd0);
    chk("ifrd_mem_en",    {31'b0, mem_en}, 32'd1);
    chk("ifrd_mem_we",    {31'b0, mem_we}, 32'd0);
    chk("ifrd_mem_addr",  mem_addr,  32'h40);
    chk("ifrd_mem_wdata", mem_wdata, 32'h0);
    cyc();
    if_req = 1'b0;
    #1;
    chk("ifrd_rvalid",  {31'b0, if_rvalid}, 32'd1);
    chk("ifrd_rdata",   if_rdata, 32'h00A0_0093);
    chk("ifrd_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    cyc();
    chk("ifrd_hold_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("ifrd_hold_rdata",  if_rdata, 32'h00A0_0093);

    // Store, then load it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_d_gnt",     {31'b0, d_gnt},  32'd1);
    chk("st_mem_we",    {31'b0, mem_we}, 32'd1);
    chk("st_mem_addr",  mem_addr,  32'h100);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("st_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    chk("st_d_rdata",  d_rdata, 32'h0);
    d_req = 1'b1; d_addr = 32'h100;
    #1;
    chk("ld_d_gnt",  {31'b0, d_gnt},  32'd1);
    chk("ld_mem_we", {31'b0, mem_we}, 32'd0);
    cyc();
    d_req = 1'b0;
    #1;
    chk("ld_d_rvalid",  {31'b0, d_rvalid}, 32'd1);
    chk("ld_d_rdata",   d_rdata, 32'hDEAD_BEEF);
    chk("ld_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("ld_if_rdata",  if_rdata, 32'h00A0_0093);
    cyc();

    // Contention: D wins 4 cycles, IF forced on the 5th, D again on the 6th.
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      #1;
      if (k <= 6) begin
        chk($sformatf("cont%0d_if_gnt", k), {31'b0, if_gnt}, {31'b0, k == 5});
        chk($sformatf("cont%0d_d_gnt", k),  {31'b0, d_gnt},  {31'b0, k != 5});
        chk($sformatf("cont%0d_mem_addr", k), mem_addr, (k == 5) ? 32'h40 : 32'h100);
      end
      if (k >= 2) begin
        chk($sformatf("cont%0d_if_rvalid", k), {31'b0, if_rvalid}, {31'b0, k == 6});
        chk($sformatf("cont%0d_d_rvalid", k),  {31'b0, d_rvalid},  {31'b0, k != 6});
        if (k == 6) chk("cont6_if_rdata", if_rdata, 32'h00A0_0093);
        else        chk($sformatf("cont%0d_d_rdata", k), d_rdata, 32'hDEAD_BEEF);
      end
      cyc();
    end

    // Pipelined IF read then D read on consecutive cycles.
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("pipe1_if_gnt", {31'b0, if_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    #1;
    chk("pipe2_d_gnt",     {31'b0, d_gnt},     32'd1);
    chk("pipe2_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("pipe2_if_rdata",  if_rdata, 32'h00A0_0093);
    chk("pipe2_d_rvalid",  {31'b0, d_rvalid},  32'd0);
    cyc();
    d_req = 1'b0;
    #1;
    chk("pipe3_d_rvalid",  {31'b0, d_rvalid},  32'd1);
    chk("pipe3_d_rdata",   d_rdata, 32'h1234_5678);
    chk("pipe3_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("pipe3_if_rdata",  if_rdata, 32'h00A0_0093);
    cyc();

    // Reset in the cycle after an IF grant discards the read.
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("rmid_if_gnt", {31'b0, if_gnt}, 32'd1);
    cyc();
    if_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rmid_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rmid_if_rdata",  if_rdata, 32'h0);
    chk("rmid_d_rdata",   d_rdata,  32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rpost_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rpost_if_rdata",  if_rdata, 32'h0);
    chk("rpost_d_rvalid",  {31'b0, d_rvalid},  32'd0);
    chk("rpost_mem_en",    {31'b0, mem_en},    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
